// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: LEGv8 PC register and instruction-fetch stage over a req/ack memory handshake,
// committing the sequential or branch-target PC when execute retires the instruction.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC          = 64'h0,
  parameter bit          HALT_ON_SELF_LOOP = 1'b1
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic [63:0] ImemAddr,
  output logic        ImemReq,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  output logic [63:0] PC,
  input  logic [63:0] BusImm,
  input  logic        Branch,
  input  logic        Uncondbranch,
  input  logic        ALUZero,
  input  logic        Retire,
  output logic        Halted
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic        r_req;
  logic        r_valid;
  logic        r_halted;
  logic        w_taken;
  logic        w_self_loop;
  logic [63:0] w_offset;
  logic [63:0] w_target;
  logic [63:0] w_seq;
  logic [63:0] w_next_pc;
  // Word offset becomes a byte offset; the two shifted-out bits are intentionally lost.
  assign w_offset    = BusImm << 2;
  assign w_taken     = Uncondbranch | (Branch & ALUZero);
  assign w_target    = r_pc + w_offset;
  assign w_seq       = r_pc + 64'd4;
  assign w_next_pc   = w_taken ? w_target : w_seq;
  assign w_self_loop = HALT_ON_SELF_LOOP && w_taken && (w_target == r_pc);
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_instr  <= 32'h0;
      r_req    <= 1'b1;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        FETCH: if (ImemAck) begin
          r_instr <= ImemData;
          r_req   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= EXEC;
        end
        EXEC: if (Retire) begin
          r_valid <= 1'b0;
          if (w_self_loop) begin
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_pc    <= w_next_pc;
            r_req   <= 1'b1;
            r_state <= FETCH;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end
  assign ImemAddr    = r_pc;
  assign PC          = r_pc;
  assign ImemReq     = r_req;
  assign Instruction = r_instr;
  assign InstrValid  = r_valid;
  assign Halted      = r_halted;
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the LEGv8 datapath.
- Holds the PC and fetches each 32-bit instruction from a variable-latency instruction memory over a req/ack handshake.
- Presents each instruction to decode. Decode extracts Imm26 and the extension control for the sign extender.
- Consumes the sign-extended BusImm, Branch, Uncondbranch and ALUZero to form the next PC when execute signals Retire.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- HALT_ON_SELF_LOOP, 1, when 1 a taken branch whose target equals the current PC halts the unit.

Ports:
- CLK  input  1  rising-edge clock
- Reset_L  input  1  asynchronous, active-low reset
- ImemAddr  output  64  fetch address; equals PC
- ImemReq  output  1  fetch request; level, held until ack
- ImemAck  input  1  memory returns ImemData this cycle
- ImemData  input  32  instruction word, valid when ImemAck=1
- Instruction  output  32  captured instruction for decode
- InstrValid  output  1  Instruction/PC valid for execute
- PC  output  64  address of Instruction
- BusImm  input  64  sign-extended word offset from the sign extender
- Branch  input  1  CBZ-type conditional branch
- Uncondbranch  input  1  B-type unconditional branch
- ALUZero  input  1  ALU zero flag for CBZ
- Retire  input  1  execute done; commit next PC
- Halted  output  1  unit stopped on self-loop

Behaviour:
- Reset (Reset_L=0, async) sets the following. Release is synchronous to the next CLK edge; the first fetch request is asserted at that edge's state.
  - PC=RESET_PC
  - state=FETCH
  - Instruction=32'h0
  - InstrValid=0
  - Halted=0
  - ImemReq=1
- Reset mid-fetch or mid-execute aborts immediately. No PC update occurs.
- States: FETCH, EXEC, HALT.
- FETCH:
  - ImemReq=1, ImemAddr=PC, InstrValid=0.
  - ImemAddr and PC must stay stable until ImemAck.
  - On ImemAck: Instruction<=ImemData, go to EXEC.
  - Latency: ack at edge n makes InstrValid=1 after edge n. A same-cycle ack (zero wait) is legal.
- EXEC:
  - ImemReq=0, InstrValid=1. Instruction and PC are held.
  - ImemAck is ignored in EXEC and HALT.
  - Taken = Uncondbranch | (Branch & ALUZero). Uncondbranch wins; the two are never both required to be 1.
  - Target = PC + (BusImm << 2), 64-bit, modulo 2^64; the shifted-out BusImm[63:62] is discarded.
  - Sequential = PC + 4, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC wraps to 0).
  - On Retire: PC <= Taken ? Target : Sequential, then go to FETCH. The new request is visible the cycle after Retire.
  - If HALT_ON_SELF_LOOP=1 and Taken and Target==PC on Retire: PC is unchanged, go to HALT.
  - Retire while not in EXEC is ignored.
  - Branch inputs are sampled only on the Retire cycle.
- HALT:
  - ImemReq=0, InstrValid=0, Halted=1.
  - Exit only via reset.
- Throughput: minimum 2 cycles per instruction (ack, then Retire).

Test Plan:
- Reset RESET_PC=0: release, ack immediately with 32'h8B020020 -> ImemReq=1, ImemAddr=0; next cycle InstrValid=1, Instruction=8B020020. Retire without branch -> next ImemAddr=4.
- Wait states: hold ImemAck=0 for 3 cycles -> ImemReq stays 1 and ImemAddr stays constant. Ack on cycle 4 -> InstrValid=1 exactly one cycle later.
- PC=0x40, Uncondbranch=1, BusImm=64'hFFFF_FFFF_FFFF_FFFE (-2), Retire -> PC=0x38. Same with BusImm=5 -> PC=0x54.
- CBZ at PC=0x100, BusImm=3: with ALUZero=0, Retire -> PC=0x104; with ALUZero=1 -> PC=0x10C.
- Self-loop: PC=0x20, Uncondbranch=1, BusImm=0, Retire -> Halted=1, ImemReq=0, PC=0x20. Further acks and retires have no effect. Reset clears Halted.
- Assert Reset_L=0 mid-wait (FETCH, no ack) at PC=0x80 -> PC=RESET_PC immediately, InstrValid=0. Also PC=0xFFFF_FFFF_FFFF_FFFC with sequential Retire -> PC=0.
